// File: rtl/half_adder_if.sv
// rtl/half_adder_if.sv - operand/result bundle for the registered half adder
//
// Purpose: groups the operand handshake and the registered results so the
//    adder and its driver share one typed connection.
// Signals:
//    in_valid     operand pair present this cycle
//    in1, in2     WIDTH-bit unsigned operands
//    out_valid    result registered from a pair accepted on the previous edge
//    sum          WIDTH-bit registered sum (mod 2^WIDTH)
//    carry        registered carry-out
//    carry_count  saturating count of accepted pairs that produced a carry
// Modports:
//    master  drives operands, observes results (the stimulus side)
//    slave   observes operands, drives results (the adder)

interface half_adder_if #(
   parameter int WIDTH     = 1,
   parameter int CNT_WIDTH = 16
);
   logic                 in_valid;
   logic [WIDTH-1:0]     in1;
   logic [WIDTH-1:0]     in2;
   logic                 out_valid;
   logic [WIDTH-1:0]     sum;
   logic                 carry;
   logic [CNT_WIDTH-1:0] carry_count;

   modport master (
      output in_valid, in1, in2,
      input  out_valid, sum, carry, carry_count
   );

   modport slave (
      input  in_valid, in1, in2,
      output out_valid, sum, carry, carry_count
   );
endinterface

// File: rtl/half_adder.sv
// rtl/half_adder.sv - registered WIDTH-bit half adder with saturating carry counter
//
// Purpose: adds two unsigned WIDTH-bit operands (no carry-in); sum and
//    carry-out are registered one clock after a valid pair. A saturating
//    counter records how many accepted pairs produced a carry.
// Ports:
//    clk    rising-edge clock
//    rst_n  synchronous active-low reset, priority over in_valid
//    ha     half_adder_if.slave: in_valid/in1/in2 in,
//           out_valid/sum/carry/carry_count out
// Parameters:
//    WIDTH      operand and sum width (1..32); must match the interface
//    CNT_WIDTH  carry counter width; must match the interface

module half_adder #(
   parameter int WIDTH     = 1,
   parameter int CNT_WIDTH = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   half_adder_if.slave   ha
);

   // One extra bit holds the carry-out of the unsigned addition.
   logic [WIDTH:0]       full;

   logic                 out_valid_q;
   logic [WIDTH-1:0]     sum_q;
   logic                 carry_q;
   logic [CNT_WIDTH-1:0] carry_count_q;

   always_comb begin
      full = {1'b0, ha.in1} + {1'b0, ha.in2};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q   <= 1'b0;
         sum_q         <= '0;
         carry_q       <= 1'b0;
         carry_count_q <= '0;
      end else begin
         out_valid_q <= ha.in_valid;
         // Operands are only looked at when in_valid is set, so undefined
         // operands on idle cycles never reach state; sum/carry hold.
         if (ha.in_valid) begin
            sum_q   <= full[WIDTH-1:0];
            carry_q <= full[WIDTH];
            // Saturate rather than wrap: an all-ones counter stays put.
            if (full[WIDTH] && (carry_count_q != {CNT_WIDTH{1'b1}})) begin
               carry_count_q <= carry_count_q + 1'b1;
            end
         end
      end
   end

   assign ha.out_valid   = out_valid_q;
   assign ha.sum         = sum_q;
   assign ha.carry       = carry_q;
   assign ha.carry_count = carry_count_q;

endmodule

// File: tb/tb_half_adder.sv
// tb/tb_half_adder.sv - self-checking bench for half_adder (1-bit, 8-bit, 2-bit counter)

module tb_half_adder;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   half_adder_if #(.WIDTH(1), .CNT_WIDTH(16)) if1 ();
   half_adder_if #(.WIDTH(8), .CNT_WIDTH(16)) if8 ();
   half_adder_if #(.WIDTH(1), .CNT_WIDTH(2))  ifs ();

   half_adder #(.WIDTH(1), .CNT_WIDTH(16)) u_w1  (.clk(clk), .rst_n(rst_n), .ha(if1));
   half_adder #(.WIDTH(8), .CNT_WIDTH(16)) u_w8  (.clk(clk), .rst_n(rst_n), .ha(if8));
   half_adder #(.WIDTH(1), .CNT_WIDTH(2))  u_sat (.clk(clk), .rst_n(rst_n), .ha(ifs));

   // The small-counter instance sees exactly the 1-bit instance's operands.
   assign ifs.in_valid = if1.in_valid;
   assign ifs.in1      = if1.in1;
   assign ifs.in2      = if1.in2;

   int checks = 0;
   int errors = 0;

   // Reference model state (arithmetic on integers, not bit logic).
   logic [31:0] ev1, es1, ec1, cnt1;
   logic [31:0] ev8, es8, ec8, cnt8;
   logic [31:0] cnts;

   // Applies one cycle of stimulus to both operand streams and advances the model.
   task automatic cyc(input bit rn, input bit v1, input int a1, input int b1,
                      input bit v8, input int a8, input int b8);
      rst_n        = rn;
      if1.in_valid = v1;
      if1.in1      = v1 ? a1[0] : 1'bx;
      if1.in2      = v1 ? b1[0] : 1'bx;
      if8.in_valid = v8;
      if8.in1      = v8 ? a8[7:0] : 8'hxx;
      if8.in2      = v8 ? b8[7:0] : 8'hxx;
      @(posedge clk);
      #1;
      if (!rn) begin
         ev1 = 0; es1 = 0; ec1 = 0; cnt1 = 0;
         ev8 = 0; es8 = 0; ec8 = 0; cnt8 = 0;
         cnts = 0;
      end else begin
         ev1 = 32'(v1);
         if (v1) begin
            es1 = 32'((a1 + b1) % 2);
            ec1 = 32'((a1 + b1) / 2);
            if (ec1 == 1) begin
               if (cnt1 < 65535) cnt1 = cnt1 + 1;
               if (cnts < 3)     cnts = cnts + 1;
            end
         end
         ev8 = 32'(v8);
         if (v8) begin
            es8 = 32'((a8 + b8) % 256);
            ec8 = 32'((a8 + b8) / 256);
            if (ec8 == 1 && cnt8 < 65535) cnt8 = cnt8 + 1;
         end
      end
   endtask

   task automatic test_reset();
      cyc(0, 1, 1, 1, 1, 255, 255);
      cyc(0, 1, 1, 1, 1, 255, 255);
      checks++; if ({if1.out_valid, if1.sum, if1.carry} !== 3'b000) begin
         errors++; $display("FAIL reset_w1 got v/s/c=%b%b%b exp 000", if1.out_valid, if1.sum, if1.carry); end
      checks++; if (if1.carry_count !== 16'd0) begin
         errors++; $display("FAIL reset_cnt1 got %0d exp 0", if1.carry_count); end
      checks++; if ({if8.out_valid, if8.sum, if8.carry} !== 10'd0) begin
         errors++; $display("FAIL reset_w8 got v=%b s=%h c=%b exp 0 00 0", if8.out_valid, if8.sum, if8.carry); end
      checks++; if (if8.carry_count !== 16'd0 || ifs.carry_count !== 2'd0) begin
         errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", if8.carry_count, ifs.carry_count); end
   endtask

   task automatic test_exhaustive_w1();
      int ta[4] = '{0, 0, 1, 1};
      int tb[4] = '{0, 1, 0, 1};
      logic [1:0] tsc[4] = '{2'b00, 2'b10, 2'b10, 2'b01};   // {sum, carry}
      for (int i = 0; i < 4; i++) begin
         cyc(1, 1, ta[i], tb[i], 0, 0, 0);
         checks++; if ({if1.sum, if1.carry} !== tsc[i] || if1.out_valid !== 1'b1) begin
            errors++; $display("FAIL exhaustive_%0d got v/s/c=%b%b%b exp 1%b", i,
                               if1.out_valid, if1.sum, if1.carry, tsc[i]); end
      end
      checks++; if (if1.carry_count !== 16'd1) begin
         errors++; $display("FAIL exhaustive_cnt got %0d exp 1", if1.carry_count); end
   endtask

   task automatic test_hold_idle();
      cyc(1, 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, 0, 0, 0, 0);
         checks++; if ({if1.out_valid, if1.sum, if1.carry} !== 3'b010) begin
            errors++; $display("FAIL hold_%0d got v/s/c=%b%b%b exp 010", i,
                               if1.out_valid, if1.sum, if1.carry); end
      end
   endtask

   task automatic test_wrap_w8();
      cyc(1, 0, 0, 0, 1, 8'hFF, 8'hFF);
      checks++; if (if8.sum !== 8'hFE || if8.carry !== 1'b1 || if8.out_valid !== 1'b1) begin
         errors++; $display("FAIL wrap_ff got s=%h c=%b v=%b exp fe 1 1", if8.sum, if8.carry, if8.out_valid); end
      cyc(1, 0, 0, 0, 1, 8'h80, 8'h7F);
      checks++; if (if8.sum !== 8'hFF || if8.carry !== 1'b0) begin
         errors++; $display("FAIL wrap_80_7f got s=%h c=%b exp ff 0", if8.sum, if8.carry); end
   endtask

   task automatic test_saturation();
      logic [1:0] steps[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      cyc(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(1, 1, 1, 1, 0, 0, 0);
         checks++; if (ifs.carry_count !== steps[i]) begin
            errors++; $display("FAIL saturate_%0d got %0d exp %0d", i, ifs.carry_count, steps[i]); end
      end
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < 3; i++) cyc(1, 1, 1, 1, 1, 200, 100);
      cyc(0, 1, 1, 1, 1, 200, 100);
      checks++; if ({if1.out_valid, if1.sum, if1.carry, if1.carry_count} !== 19'd0 ||
                    {if8.out_valid, if8.sum, if8.carry, if8.carry_count} !== 26'd0 ||
                    ifs.carry_count !== 2'd0) begin
         errors++; $display("FAIL midreset got w1 v=%b c=%b n=%0d w8 v=%b s=%h n=%0d sat=%0d exp all 0",
                            if1.out_valid, if1.carry, if1.carry_count,
                            if8.out_valid, if8.sum, if8.carry_count, ifs.carry_count); end
      cyc(1, 1, 1, 1, 0, 0, 0);
      checks++; if (if1.carry !== 1'b1 || if1.carry_count !== 16'd1 || ifs.carry_count !== 2'd1) begin
         errors++; $display("FAIL midreset_next got c=%b n=%0d sat=%0d exp 1 1 1",
                            if1.carry, if1.carry_count, ifs.carry_count); end
   endtask

   task automatic test_random();
      int a8, b8;
      for (int i = 0; i < 300; i++) begin
         a8 = int'($urandom_range(0, 255));
         b8 = int'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) a8 = 255;
         cyc(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) != 0), a8, b8);
         checks++; if (32'(if1.out_valid) !== ev1 || 32'(if1.sum) !== es1 || 32'(if1.carry) !== ec1 ||
                       32'(if1.carry_count) !== cnt1 || 32'(ifs.carry_count) !== cnts) begin
            errors++; $display("FAIL random_w1_%0d got v=%b s=%b c=%b n=%0d sat=%0d exp %0d %0d %0d %0d %0d", i,
                               if1.out_valid, if1.sum, if1.carry, if1.carry_count, ifs.carry_count,
                               ev1, es1, ec1, cnt1, cnts); end
         checks++; if (32'(if8.out_valid) !== ev8 || 32'(if8.sum) !== es8 || 32'(if8.carry) !== ec8 ||
                       32'(if8.carry_count) !== cnt8) begin
            errors++; $display("FAIL random_w8_%0d got v=%b s=%h c=%b n=%0d exp %0d %0h %0d %0d", i,
                               if8.out_valid, if8.sum, if8.carry, if8.carry_count, ev8, es8, ec8, cnt8); end
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      if1.in_valid = 1'b0; if1.in1 = 1'b0; if1.in2 = 1'b0;
      if8.in_valid = 1'b0; if8.in1 = 8'h00; if8.in2 = 8'h00;
      test_reset();
      test_exhaustive_w1();
      test_hold_idle();
      test_wrap_w8();
      test_saturation();
      test_reset_midstream();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
